// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, LSB-first data, optional parity, stop bit.
// Optional parity stage enabled by defining PARITY_EN.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdi,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DATA, STOP
  } state_t;
`endif

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;
  logic              perr;
  logic              good;
  logic              hs;
  logic              load;
  logic              drop;

`ifdef PARITY_EN
  logic par_bit;
  assign perr = ^{shreg, par_bit};
`else
  assign perr = 1'b0;
`endif

  assign last_bit = (bit_cnt == CW'(DATA_W - 1));
  assign good     = (state == STOP) && !sdi;
  assign hs       = rx_valid && rx_ready;
  assign load     = good && (!rx_valid || rx_ready);
  assign drop     = good && rx_valid && !rx_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (sdi) state_n = DATA;
`ifdef PARITY_EN
      DATA:   if (last_bit) state_n = PARITY;
      PARITY: state_n = STOP;
`else
      DATA:   if (last_bit) state_n = STOP;
`endif
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (state == IDLE)
        bit_cnt <= '0;
      // LSB arrives first, so shifting right lands it in bit 0
      if (state == DATA) begin
        shreg   <= {sdi, shreg[DATA_W-1:1]};
        bit_cnt <= bit_cnt + CW'(1);
      end
`ifdef PARITY_EN
      if (state == PARITY)
        par_bit <= sdi;
`endif
      if ((state == STOP) && sdi)
        frame_err <= 1'b1;
      if (load) begin
        rx_data    <= shreg;
        parity_err <= perr;
        rx_valid   <= 1'b1;
      end else if (drop) begin
        overrun <= 1'b1;
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (DATA_W=8).
// Adapts frame length to whether PARITY_EN is defined.
module tb_serial_frame_rx;

  logic       clk;
  logic       reset;
  logic       sdi;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp;
  int n_err;

  logic [8:0] sb[$];

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sdi        (sdi),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the stop edge.
  task automatic send_frame(input logic [7:0] d,
                            input bit bad_par,
                            input bit stop1,
                            input bit ovr);
    logic pe;
    sdi = 1'b1;
    @(negedge clk);
    check("busy_hi", busy, 1);
    for (int i = 0; i < 8; i++) begin
      sdi = d[i];
      @(negedge clk);
    end
`ifdef PARITY_EN
    sdi = (^d) ^ bad_par;
    @(negedge clk);
    pe = bad_par;
`else
    pe = 1'b0;
`endif
    sdi = stop1;
    @(negedge clk);
    check("frame_err", frame_err, stop1);
    check("overrun", overrun, ovr);
    check("rx_valid", rx_valid, !stop1);
    check("busy_lo", busy, 0);
    if (!stop1 && !ovr)
      sb.push_back({pe, d});
    sdi = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    #1;
    if (!reset && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rx_data", rx_data, e[7:0]);
        check("parity_err", parity_err, e[8]);
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    sdi      = 1'b0;
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);

    send_frame(8'hA5, 0, 0, 0);
    @(negedge clk);
    check("valid_1cyc", rx_valid, 0);

    send_frame(8'h01, 1, 0, 0);
    @(negedge clk);

    send_frame(8'h7E, 0, 1, 0);
    @(negedge clk);
    check("ferr_1cyc", frame_err, 0);
    send_frame(8'h42, 0, 0, 0);
    @(negedge clk);

    rx_ready = 1'b0;
    send_frame(8'h11, 0, 0, 0);
    @(negedge clk);
    send_frame(8'h22, 0, 0, 1);
    check("ovr_keep", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_drain", rx_valid, 0);
    check("ovr_1cyc", overrun, 0);
    rx_ready = 1'b1;
    @(negedge clk);

    send_frame(8'h3C, 0, 0, 0);
    send_frame(8'hC3, 0, 0, 0);
    @(negedge clk);

    sdi = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sdi = i[0];
      @(negedge clk);
    end
    reset = 1'b1;
    sdi   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", rx_valid, 0);
    send_frame(8'h5A, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial-to-parallel receiver that sits directly downstream of the SISO shift register and consumes its serial output stream. It sits idle on a low line, detects a start bit, shifts in DATA_W data bits LSB first, optionally checks parity, and validates the stop bit. It then presents the word on a one-entry valid/ready output buffer, flagging overrun and framing errors.

## Interface
- DATA_W, 8, data bits per frame (≥2)
- clk  input  1  rising-edge clock; one serial bit per cycle
- reset  input  1  synchronous, active-high reset
- sdi  input  1  serial line; idle level 0
- rx_data  output  DATA_W  received word, valid while rx_valid=1
- rx_valid  output  1  output buffer holds a word
- rx_ready  input  1  consumer accepts word when rx_valid&&rx_ready at posedge
- parity_err  output  1  sideband of rx_data, valid with rx_valid
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1
- overrun  output  1  one-cycle pulse: completed word dropped, buffer full
- busy  output  1  state != IDLE

## Operation
- Frame on sdi, one bit per posedge: start bit (1), DATA_W data bits LSB first, parity bit (PARITY_EN only), stop bit (0).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sdi=1 -> DATA, bit_cnt=0; else stay.
  - DATA: shift sdi into bit position bit_cnt; bit_cnt increments; after bit DATA_W-1 -> PARITY (PARITY_EN) or STOP.
  - PARITY: capture parity bit -> STOP.
  - STOP: sdi=0 -> frame good, attempt buffer load; sdi=1 -> frame_err pulse, word discarded. Always -> IDLE.
- Buffer load on good frame:
  - rx_valid=0, or handshake in the same cycle: rx_data/parity_err loaded, rx_valid=1.
  - rx_valid=1 and no handshake: new word dropped, old word and parity_err kept, overrun pulses.
- Handshake without load: rx_valid -> 0; rx_data holds its last value.
- Parity: even over data plus parity bit. Mismatch sets parity_err=1 alongside the word. The word is still delivered.
- Reset at any point aborts the frame and discards partial data. No word is emitted for an aborted frame.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, bit_cnt=0.
- Start bit sampled at edge k.
  - Data bit i sampled at edge k+1+i.
  - Parity bit sampled at k+1+DATA_W.
  - Stop bit sampled at k+1+DATA_W+P, where P=1 with PARITY_EN and 0 otherwise.
- rx_valid, frame_err and overrun are registered at the stop-bit edge and visible in the following cycle. Latency from start edge is DATA_W+2+P edges.
- busy goes high the cycle after the start edge and low the cycle after the stop edge.
- Back-to-back frames are supported with no idle gap: a start bit may be sampled at the edge immediately after the stop edge.
- An isolated 1 on an idle line is a start bit. It yields a frame of all-zero data if the following bits stay 0.
- Simultaneous handshake and load: the buffer is replaced without rx_valid dropping, and overrun stays 0.

## Configuration
- PARITY_EN defined: PARITY state present, frame is DATA_W+3 bits, parity_err computed as above.
- PARITY_EN undefined: no PARITY state, frame is DATA_W+2 bits, parity_err tied to 0.

## Test plan
All scenarios use DATA_W=8 with PARITY_EN defined unless stated otherwise.
- Reset, then frame 0xA5 (bit sequence on sdi: 1,1,0,1,0,0,1,0,1,0,0) with rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 cycle, 11 edges after the start edge; parity_err=0, frame_err=0.
- Frame 0x01 with parity bit 0 -> rx_data=0x01, parity_err=1 with rx_valid.
- Frame 0x7E with stop bit 1 -> frame_err pulses 1 cycle, rx_valid stays 0, next frame 0x42 received correctly.
- rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses at the 0x22 stop edge. Then rx_ready=1 for one cycle -> rx_valid=0.
- rx_ready=1, back-to-back 0x3C and 0xC3 with no gap -> both words delivered in order; overrun=0.
- Reset asserted for one cycle after 4 data bits of a frame -> busy=0, rx_valid=0. Following frame 0x5A -> rx_data=0x5A. Repeat with PARITY_EN undefined: 0x5A received 10 edges after start, parity_err=0.
